sg_serial_loader: RTL and testbench
===================================

Name: sg_serial_loader

Overview:
Upstream register loader for the signal generator.
- Receives 8-bit serial write frames: 3-bit address plus 5-bit data, MSB first.
- Each frame arrives on a slow 3-wire port (ser_clk/ser_dat/ser_cs_n) driven from the chip pins.
- Frames are buffered in a small FIFO.
- Each buffered frame is replayed as a clean single-cycle write_strobe with stable address/data, which connects directly to signal_generator's write port.

Parameters:
FIFO_DEPTH, 4, number of buffered frames (power of 2, ≥2)
SYNC_STAGES, 2, flip-flop stages on each serial input
STROBE_GAP, 2, idle cycles enforced after each write_strobe (≥1)

Ports:
clk  in  1  system clock
rst  in  1  reset, synchronous, active-high
ser_clk  in  1  serial bit clock, asynchronous pin; data sampled on its rising edge
ser_dat  in  1  serial data, asynchronous pin
ser_cs_n  in  1  frame select, active-low, asynchronous pin
write_strobe  out  1  one-cycle write pulse to signal_generator
address  out  3  register address, valid while write_strobe high and held until next write
data  out  5  register data, same validity as address
fifo_full  out  1  FIFO holds FIFO_DEPTH entries
overrun  out  1  sticky: frame dropped because FIFO full
parity_err  out  1  sticky parity error (see Optional Feature)

Behaviour:
- Interface: one clock (clk); reset synchronous active-high (rst). Everything is sampled on the rising edge of clk.
- Reset values: write_strobe=0, address=0, data=0, fifo_full=0, overrun=0, parity_err=0. Reset also:
  - empties the FIFO;
  - clears the bit counter and shift register;
  - sets the sync chains to ser_clk=0 and ser_cs_n=1;
  - puts the FSM in IDLE.
- Reset mid-frame or mid-strobe aborts everything. The partial frame is lost and no strobe is emitted on the following cycle.
- Input stage: ser_clk, ser_dat and ser_cs_n each pass through SYNC_STAGES flops.
- Bit sampling: a rising edge of synced ser_clk (sync=1, previous=0) while synced ser_cs_n=0 shifts synced ser_dat into the shift register. The bit counter increments.
- Pin timing: ser_clk high and low phases must each be ≥ SYNC_STAGES+1 clk periods. Faster input is outside spec (no detection).
- Frame completion: on the 8th bit the frame {addr[2:0], data[4:0]} is pushed and the counter returns to 0. With ser_cs_n still low, further bits form back-to-back frames (burst writes).
- ser_cs_n rising mid-frame (counter ≠ 0): partial frame discarded, counter cleared, no push.
- ser_clk edges while ser_cs_n high are ignored.
- FIFO full on push: frame dropped and overrun set. overrun is cleared only by rst.
- Push and pop in the same cycle when full: push accepted and occupancy unchanged.
- fifo_full is registered and reflects occupancy after the current cycle's push/pop.
- Output FSM has three states:
  - IDLE: if FIFO not empty, pop; address/data load from the FIFO head; write_strobe=1 next cycle; go to STROBE.
  - STROBE (1 cycle): write_strobe=1; go to GAP.
  - GAP: write_strobe=0 for STROBE_GAP cycles; return to IDLE.
- address/data stay constant from the STROBE cycle until the next pop.
- Latency: with FIFO empty and FSM in IDLE, write_strobe rises exactly SYNC_STAGES+3 clk cycles after the clk edge that first samples the 8th ser_clk rising level.
- Throughput: one write per STROBE_GAP+2 cycles.

Optional Feature:
Macro SG_LOADER_PARITY_EN.
- Defined: frames are 9 bits; the 9th bit is even parity over the preceding 8.
  - Mismatch: frame dropped, parity_err set (sticky, cleared by rst), no push and no overrun change.
  - Match: normal push.
- Undefined: 8-bit frames; parity_err tied 0.

Decomposition:
- Package sg_pkg holds ADDR_W=3, DATA_W=5, FRAME_W (8, or 9 with parity) and the FSM state enum {IDLE, STROBE, GAP}.
- One sub-module, sg_sync_fifo: a synchronous FIFO (width ADDR_W+DATA_W, depth FIFO_DEPTH) with push/pop/full/empty and simultaneous push/pop when full.
- Synchronizers, shifter and FSM live in sg_serial_loader.

Test Plan:
- Single frame 0b101_10011 (ser_clk half-period 4 clk) → exactly one write_strobe at SYNC_STAGES+3 cycles after the last bit; address=5, data=19, held afterwards.
- Burst of 3 frames (5/1, 2/7, 7/31) with cs_n held low → three strobes in order, spaced exactly STROBE_GAP+2=4 cycles apart.
- ser_cs_n raised after 5 bits, then full frame 3/9 → only one strobe, address=3, data=9.
- 6 frames sent while the FSM is stalled by forced back-to-back input (FIFO_DEPTH=4) → fifo_full=1, overrun=1, the first 4 frames strobed in order, overrun still 1 afterwards.
- rst asserted during bit 4 of a frame and again on the STROBE cycle → all outputs 0 on the next cycle, no further strobe, FIFO empty.
- With SG_LOADER_PARITY_EN: frame 1/1 with wrong parity → no strobe, parity_err=1; frame 1/1 with correct parity → strobe with address=1, data=1.

Source files
------------

// File: rtl/sg_pkg.sv
// sg_pkg: shared widths and FSM states for the serial register loader.
// SG_LOADER_PARITY_EN widens frames to 9 bits (trailing even-parity bit).
package sg_pkg;
    localparam int ADDR_W  = 3;
    localparam int DATA_W  = 5;
    localparam int ENTRY_W = ADDR_W + DATA_W;
`ifdef SG_LOADER_PARITY_EN
    localparam int FRAME_W = 9;
`else
    localparam int FRAME_W = 8;
`endif
    localparam int CNT_W   = 4;
    typedef enum logic [1:0] {IDLE, STROBE, GAP} state_t;
endpackage

// File: rtl/sg_sync_fifo.sv
// sg_sync_fifo: single-clock FIFO; a push into a full FIFO is accepted when a pop happens in the same cycle.
module sg_sync_fifo
    import sg_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int W     = ENTRY_W
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         push,
    input  logic         pop,
    input  logic [W-1:0] wdata,
    output logic [W-1:0] rdata,
    output logic         full,
    output logic         empty
);
    localparam int AW = $clog2(DEPTH);
    logic [W-1:0] mem [DEPTH];
    logic [AW-1:0] wr_ptr, rd_ptr;
    logic [AW:0] count;
    logic do_push, do_pop;

    assign do_pop  = pop & ~empty;
    assign do_push = push & (~full | do_pop);
    assign full    = count == (AW+1)'(DEPTH);
    assign empty   = count == '0;
    assign rdata   = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= wdata;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop) rd_ptr <= rd_ptr + 1'b1;
            count <= count + (AW+1)'(do_push) - (AW+1)'(do_pop);
        end
    end
endmodule

// File: rtl/sg_serial_loader.sv
// sg_serial_loader: 3-wire serial frame receiver replaying buffered frames as single-cycle write strobes.
// SG_LOADER_PARITY_EN: 9-bit frames, trailing even-parity bit checked, bad frames dropped.
module sg_serial_loader
    import sg_pkg::*;
#(
    parameter int FIFO_DEPTH  = 4,
    parameter int SYNC_STAGES = 2,
    parameter int STROBE_GAP  = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              ser_clk,
    input  logic              ser_dat,
    input  logic              ser_cs_n,
    output logic              write_strobe,
    output logic [ADDR_W-1:0] address,
    output logic [DATA_W-1:0] data,
    output logic              fifo_full,
    output logic              overrun,
    output logic              parity_err
);
    localparam int GW = $clog2(STROBE_GAP + 1);
    logic [SYNC_STAGES-1:0] clk_sync, dat_sync, cs_sync;
    logic clk_prev, rise, last_bit, frame_vld, push, pop, fifo_empty, gap_done;
    logic [CNT_W-1:0] bit_cnt;
    logic [FRAME_W-2:0] shift;
    logic [FRAME_W-1:0] frame, frame_q;
    logic [ENTRY_W-1:0] fifo_wdata, head;
    logic [GW-1:0] gap_cnt;
    state_t state, state_n;

    assign rise     = clk_sync[SYNC_STAGES-1] & ~clk_prev & ~cs_sync[SYNC_STAGES-1];
    assign frame    = {shift, dat_sync[SYNC_STAGES-1]};
    assign last_bit = rise && bit_cnt == CNT_W'(FRAME_W - 1);

    always_ff @(posedge clk) begin
        if (rst) begin
            clk_sync  <= '0;
            dat_sync  <= '0;
            cs_sync   <= '1;
            clk_prev  <= 1'b0;
            bit_cnt   <= '0;
            shift     <= '0;
            frame_q   <= '0;
            frame_vld <= 1'b0;
        end else begin
            clk_sync  <= {clk_sync[SYNC_STAGES-2:0], ser_clk};
            dat_sync  <= {dat_sync[SYNC_STAGES-2:0], ser_dat};
            cs_sync   <= {cs_sync[SYNC_STAGES-2:0], ser_cs_n};
            clk_prev  <= clk_sync[SYNC_STAGES-1];
            frame_vld <= last_bit;
            if (last_bit) frame_q <= frame;
            if (rise) shift <= frame[FRAME_W-2:0];
            if (cs_sync[SYNC_STAGES-1]) bit_cnt <= '0;
            else if (rise) bit_cnt <= last_bit ? '0 : bit_cnt + 1'b1;
        end
    end

`ifdef SG_LOADER_PARITY_EN
    logic parity_ok;
    assign parity_ok  = ~^frame_q;
    assign push       = frame_vld & parity_ok;
    assign fifo_wdata = frame_q[FRAME_W-1:1];
    always_ff @(posedge clk) begin
        if (rst) parity_err <= 1'b0;
        else if (frame_vld && !parity_ok) parity_err <= 1'b1;
    end
`else
    assign push       = frame_vld;
    assign fifo_wdata = frame_q;
    assign parity_err = 1'b0;
`endif

    sg_sync_fifo #(.DEPTH(FIFO_DEPTH), .W(ENTRY_W)) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (push),
        .pop   (pop),
        .wdata (fifo_wdata),
        .rdata (head),
        .full  (fifo_full),
        .empty (fifo_empty)
    );

    always_ff @(posedge clk) begin
        if (rst) overrun <= 1'b0;
        else if (push && fifo_full && !pop) overrun <= 1'b1;
    end

    assign gap_done = gap_cnt == GW'(STROBE_GAP - 1);

    always_comb begin
        pop     = state == IDLE && !fifo_empty;
        state_n = pop ? STROBE : state == STROBE ? GAP : (state == GAP && gap_done) ? IDLE : state;
    end

    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else state <= state_n;
    end

    // strobe is registered off STROBE so address/data settle one cycle before it
    always_ff @(posedge clk) begin
        if (rst) begin
            write_strobe <= 1'b0;
            address      <= '0;
            data         <= '0;
            gap_cnt      <= '0;
        end else begin
            write_strobe <= state == STROBE;
            gap_cnt      <= state == GAP ? gap_cnt + 1'b1 : '0;
            if (pop) {address, data} <= head;
        end
    end
endmodule

// File: tb/tb_sg_serial_loader.sv
// tb_sg_serial_loader: scoreboard bench driving the 3-wire port and checking replayed write strobes.
module tb_sg_serial_loader;
    import sg_pkg::*;
    localparam int SS = 2, GAPC = 2, HP = 4;
    logic clk = 0, rst = 1, ser_clk = 0, ser_dat = 0, ser_cs_n = 1;
    logic write_strobe, fifo_full, overrun, parity_err;
    logic [2:0] address;
    logic [4:0] data;
    int cyc = 0, nchk = 0, nerr = 0, last_rise = 0;
    typedef struct {int c; logic [7:0] v;} obs_t;
    obs_t obs_q[$], mon_o;
    logic [7:0] exp_q[$];

    sg_serial_loader #(.FIFO_DEPTH(4), .SYNC_STAGES(SS), .STROBE_GAP(GAPC)) dut (
        .clk(clk), .rst(rst), .ser_clk(ser_clk), .ser_dat(ser_dat), .ser_cs_n(ser_cs_n),
        .write_strobe(write_strobe), .address(address), .data(data),
        .fifo_full(fifo_full), .overrun(overrun), .parity_err(parity_err)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc++;
    always @(negedge clk) begin
        if (write_strobe === 1'b1) begin
            mon_o.c = cyc;
            mon_o.v = {address, data};
            obs_q.push_back(mon_o);
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic send_bit(input logic b);
        ser_clk = 0; ser_dat = b; tick(HP);
        ser_clk = 1; last_rise = cyc; tick(HP);
    endtask

    task automatic send_frame(input logic [2:0] a, input logic [4:0] d, input logic bad);
        logic [8:0] f;
        int n;
`ifdef SG_LOADER_PARITY_EN
        f = {a, d, ^{a, d} ^ bad}; n = 9;
`else
        f = {bad, a, d}; n = 8;
`endif
        for (int i = n - 1; i >= 0; i--) send_bit(f[i]);
        ser_clk = 0; tick(HP);
    endtask

    task automatic test_reset;
        rst = 1; tick(3);
        nchk++;
        if ({write_strobe, address, data} !== 9'd0) begin
            nerr++; $display("FAIL reset_out got=%b want=0", {write_strobe, address, data});
        end
        nchk++;
        if ({fifo_full, overrun, parity_err} !== 3'b000) begin
            nerr++; $display("FAIL reset_flags got=%b want=000", {fifo_full, overrun, parity_err});
        end
        rst = 0; tick(2);
    endtask

    task automatic test_single;
        obs_t o;
        logic [7:0] v;
        obs_q.delete(); exp_q.delete();
        ser_cs_n = 0; tick(HP);
        exp_q.push_back(8'b101_10011);
        send_frame(3'd5, 5'd19, 1'b0);
        ser_cs_n = 1; tick(40);
        nchk++;
        if (obs_q.size() != 1) begin
            nerr++; $display("FAIL single_count got=%0d want=1", obs_q.size());
        end
        if (obs_q.size() > 0) begin
            o = obs_q.pop_front(); v = exp_q.pop_front();
            nchk++;
            if (o.v !== v) begin nerr++; $display("FAIL single_value got=%h want=%h", o.v, v); end
            // edge that samples the rise is one cycle after it is driven, strobe sampled one negedge later
            nchk++;
            if (o.c - last_rise != SS + 4) begin
                nerr++; $display("FAIL single_latency got=%0d want=%0d", o.c - last_rise, SS + 4);
            end
        end
        nchk++;
        if ({write_strobe, address, data} !== {1'b0, 3'd5, 5'd19}) begin
            nerr++; $display("FAIL single_hold got=%b want=%b", {write_strobe, address, data}, {1'b0, 3'd5, 5'd19});
        end
    endtask

    task automatic test_burst;
        obs_t o;
        logic [7:0] v;
        int prev;
        logic [7:0] fr [3];
        fr[0] = {3'd5, 5'd1}; fr[1] = {3'd2, 5'd7}; fr[2] = {3'd7, 5'd31};
        obs_q.delete(); exp_q.delete();
        force dut.state = GAP;
        ser_cs_n = 0; tick(HP);
        for (int i = 0; i < 3; i++) begin
            exp_q.push_back(fr[i]);
            send_frame(fr[i][7:5], fr[i][4:0], 1'b0);
        end
        ser_cs_n = 1; tick(2);
        release dut.state;
        tick(40);
        nchk++;
        if (obs_q.size() != 3) begin
            nerr++; $display("FAIL burst_count got=%0d want=3", obs_q.size());
        end
        prev = -1;
        while (obs_q.size() > 0 && exp_q.size() > 0) begin
            o = obs_q.pop_front(); v = exp_q.pop_front();
            nchk++;
            if (o.v !== v) begin nerr++; $display("FAIL burst_value got=%h want=%h", o.v, v); end
            if (prev >= 0) begin
                nchk++;
                if (o.c - prev != GAPC + 2) begin
                    nerr++; $display("FAIL burst_spacing got=%0d want=%0d", o.c - prev, GAPC + 2);
                end
            end
            prev = o.c;
        end
    endtask

    task automatic test_abort;
        obs_t o;
        obs_q.delete(); exp_q.delete();
        ser_cs_n = 0; tick(HP);
        for (int i = 0; i < 5; i++) send_bit(1'(i));
        ser_clk = 0; tick(HP);
        ser_cs_n = 1; tick(HP);
        ser_cs_n = 0; tick(HP);
        exp_q.push_back({3'd3, 5'd9});
        send_frame(3'd3, 5'd9, 1'b0);
        ser_cs_n = 1; tick(40);
        nchk++;
        if (obs_q.size() != 1) begin
            nerr++; $display("FAIL abort_count got=%0d want=1", obs_q.size());
        end
        if (obs_q.size() > 0) begin
            o = obs_q.pop_front();
            nchk++;
            if (o.v !== exp_q[0]) begin nerr++; $display("FAIL abort_value got=%h want=%h", o.v, exp_q[0]); end
        end
    endtask

    task automatic test_overrun;
        obs_t o;
        logic [7:0] v;
        obs_q.delete(); exp_q.delete();
        force dut.state = GAP;
        ser_cs_n = 0; tick(HP);
        for (int i = 0; i < 6; i++) begin
            v = 8'(i * 37 + 3);
            if (i < 4) exp_q.push_back(v);
            send_frame(v[7:5], v[4:0], 1'b0);
        end
        ser_cs_n = 1; tick(2);
        nchk++;
        if ({fifo_full, overrun} !== 2'b11) begin
            nerr++; $display("FAIL overrun_flags got=%b want=11", {fifo_full, overrun});
        end
        release dut.state;
        tick(40);
        nchk++;
        if (obs_q.size() != 4) begin
            nerr++; $display("FAIL overrun_count got=%0d want=4", obs_q.size());
        end
        while (obs_q.size() > 0 && exp_q.size() > 0) begin
            o = obs_q.pop_front(); v = exp_q.pop_front();
            nchk++;
            if (o.v !== v) begin nerr++; $display("FAIL overrun_value got=%h want=%h", o.v, v); end
        end
        nchk++;
        if ({fifo_full, overrun} !== 2'b01) begin
            nerr++; $display("FAIL overrun_sticky got=%b want=01", {fifo_full, overrun});
        end
    endtask

    task automatic test_reset_mid;
        obs_t o;
        obs_q.delete(); exp_q.delete();
        ser_cs_n = 0; tick(HP);
        for (int i = 0; i < 3; i++) send_bit(1'b1);
        ser_clk = 0; ser_dat = 1; tick(HP);
        ser_clk = 1; tick(1);
        rst = 1; tick(1); rst = 0;
        nchk++;
        if ({write_strobe, address, data, fifo_full, overrun, parity_err} !== 12'd0) begin
            nerr++; $display("FAIL rst_frame_out got=%b want=0", {write_strobe, address, data, fifo_full, overrun, parity_err});
        end
        tick(HP);
        for (int i = 0; i < 4; i++) send_bit(1'b0);
        ser_clk = 0; tick(HP);
        ser_cs_n = 1; tick(40);
        nchk++;
        if (obs_q.size() != 0) begin
            nerr++; $display("FAIL rst_frame_strobes got=%0d want=0", obs_q.size());
        end
        fork
            begin
                ser_cs_n = 0; tick(HP);
                send_frame(3'd6, 5'd21, 1'b0);
                ser_cs_n = 1;
            end
        join_none
        for (int i = 0; i < 200 && write_strobe !== 1'b1; i++) tick(1);
        nchk++;
        if (write_strobe !== 1'b1) begin
            nerr++; $display("FAIL rst_strobe_wait got=%b want=1 (timeout)", write_strobe);
        end
        rst = 1; tick(1); rst = 0;
        nchk++;
        if ({write_strobe, address, data, fifo_full, overrun, parity_err} !== 12'd0) begin
            nerr++; $display("FAIL rst_strobe_out got=%b want=0", {write_strobe, address, data, fifo_full, overrun, parity_err});
        end
        wait fork;
        obs_q.delete();
        tick(30);
        nchk++;
        if (obs_q.size() != 0) begin
            nerr++; $display("FAIL rst_strobe_extra got=%0d want=0", obs_q.size());
        end
        ser_cs_n = 0; tick(HP);
        exp_q.push_back({3'd2, 5'd10});
        send_frame(3'd2, 5'd10, 1'b0);
        ser_cs_n = 1; tick(40);
        nchk++;
        if (obs_q.size() != 1) begin
            nerr++; $display("FAIL rst_fifo_empty got=%0d want=1", obs_q.size());
        end
        if (obs_q.size() > 0) begin
            o = obs_q.pop_front();
            nchk++;
            if (o.v !== exp_q[0]) begin nerr++; $display("FAIL rst_after_value got=%h want=%h", o.v, exp_q[0]); end
        end
    endtask

`ifdef SG_LOADER_PARITY_EN
    task automatic test_parity;
        obs_t o;
        obs_q.delete(); exp_q.delete();
        ser_cs_n = 0; tick(HP);
        send_frame(3'd1, 5'd1, 1'b1);
        ser_cs_n = 1; tick(40);
        nchk++;
        if (obs_q.size() != 0 || parity_err !== 1'b1 || overrun !== 1'b0) begin
            nerr++; $display("FAIL parity_bad got=%0d/%b/%b want=0/1/0", obs_q.size(), parity_err, overrun);
        end
        ser_cs_n = 0; tick(HP);
        exp_q.push_back({3'd1, 5'd1});
        send_frame(3'd1, 5'd1, 1'b0);
        ser_cs_n = 1; tick(40);
        nchk++;
        if (obs_q.size() != 1) begin
            nerr++; $display("FAIL parity_good_count got=%0d want=1", obs_q.size());
        end
        if (obs_q.size() > 0) begin
            o = obs_q.pop_front();
            nchk++;
            if (o.v !== exp_q[0]) begin nerr++; $display("FAIL parity_good_value got=%h want=%h", o.v, exp_q[0]); end
        end
    endtask
`endif

    initial begin
        test_reset();
        test_single();
        test_burst();
        test_abort();
        test_overrun();
        test_reset_mid();
`ifdef SG_LOADER_PARITY_EN
        test_parity();
`endif
        $display("Result: errors=%0d of %0d checks", nerr, nchk);
        $finish;
    end
endmodule
